// File: rtl/ula_serial_ctrl_if.sv
// Request/response bus between the MIPS control/datapath and the serial ULA sequencer.
// ULA_SERIAL_FLAGS_EN adds the zero/ovf status flags to the response side.
interface ula_serial_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       ulaOp;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
`ifdef ULA_SERIAL_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (
    output start, ulaOp, op_a, op_b,
    input  busy, done, result, zero, ovf
  );

  modport slave (
    input  start, ulaOp, op_a, op_b,
    output busy, done, result, zero, ovf
  );
`else
  modport master (
    output start, ulaOp, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, ulaOp, op_a, op_b,
    output busy, done, result
  );
`endif
endinterface

// File: rtl/ula_serial_ctrl.sv
// Bit-serial sequencer for the 1-bit ULA slice: LSB first, carry fed back bit to bit.
// Define ULA_SERIAL_FLAGS_EN to add the registered zero/ovf flags on the bus.
module ula_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  ula_serial_ctrl_if.slave      bus,
  output logic [2:0]            slice_op,
  output logic                  slice_a,
  output logic                  slice_b,
  output logic                  slice_cin,
  input  logic                  slice_y,
  input  logic                  slice_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             op_valid;
  logic             last_bit;
  logic             msb_ovf;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] final_res;

  always_comb begin
    op_valid = (bus.ulaOp == OP_AND) || (bus.ulaOp == OP_OR) || (bus.ulaOp == OP_ADD) ||
               (bus.ulaOp == OP_SUB) || (bus.ulaOp == OP_SLT);
  end

  assign last_bit = (idx_q == CW'(WIDTH - 1));
  // At the MSB the carry flop is the carry in, so in/out disagreement means signed overflow.
  assign msb_ovf  = carry_q ^ slice_cout;
  assign shifted  = {slice_y, result_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    final_res = shifted;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d     = bus.ulaOp;
          a_d      = bus.op_a;
          b_d      = bus.op_b;
          idx_d    = '0;
          carry_d  = (bus.ulaOp == OP_SUB) || (bus.ulaOp == OP_SLT);
          result_d = '0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
          if (op_valid) begin
            state_d = S_RUN;
            zero_d  = 1'b0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            zero_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = slice_cout;
        idx_d   = idx_q + CW'(1);
        if (op_q == OP_SLT) begin
          final_res = {{(WIDTH-1){1'b0}}, slice_y ^ msb_ovf};
        end
        if (last_bit) begin
          result_d = final_res;
          state_d  = S_DONE;
          done_d   = 1'b1;
          zero_d   = (final_res == '0);
          ovf_d    = ((op_q == OP_ADD) || (op_q == OP_SUB)) && msb_ovf;
        end else begin
          result_d = shifted;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  // Slice drive comes straight from flops; SLT runs on the slice as a subtract.
  always_comb begin
    slice_op  = 3'b000;
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    if (state_q == S_RUN) begin
      slice_op  = (op_q == OP_SLT) ? OP_SUB : op_q;
      slice_a   = a_q[0];
      slice_b   = b_q[0];
      slice_cin = carry_q;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

`ifdef ULA_SERIAL_FLAGS_EN
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;
`else
  logic unused_flags;
  assign unused_flags = zero_q ^ ovf_q;
`endif

endmodule
